// File: rtl/bus_arbiter.sv
// Round-robin owner select for a shared tristate bus, with a forced one-cycle turnaround between owners.
// Optional grant timeout with preempt pulse: define BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         enable,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       bus_busy,
   output logic                       preempted
);
   localparam int GW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
      $error("bus_arbiter: NUM_REQ or MAX_HOLD out of range");
   end

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t             state_q;
   logic [NUM_REQ-1:0] enable_q;
   logic [GW-1:0]      grant_id_q;
   logic [GW-1:0]      last_q;

   logic [GW-1:0]      win_d;
   logic [NUM_REQ-1:0] win_oh_d;
   logic               found_d;
   logic [GW:0]        idx;

   // Search upward from last_q+1 with wrap, so the previous owner ranks last.
   always_comb begin
      win_d   = '0;
      found_d = 1'b0;
      idx     = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = {1'b0, last_q} + (GW+1)'(i);
         if (idx >= (GW+1)'(NUM_REQ)) idx = idx - (GW+1)'(NUM_REQ);
         if (!found_d && req[idx[GW-1:0]]) begin
            found_d = 1'b1;
            win_d   = idx[GW-1:0];
         end
      end
      win_oh_d        = '0;
      win_oh_d[win_d] = 1'b1;
   end

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0] hold_q;
   logic          preempted_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         enable_q   <= '0;
         grant_id_q <= '0;
         last_q     <= GW'(NUM_REQ - 1);
`ifdef BUS_ARB_TIMEOUT_EN
         hold_q      <= '0;
         preempted_q <= 1'b0;
`endif
      end else begin
`ifdef BUS_ARB_TIMEOUT_EN
         preempted_q <= 1'b0;
`endif
         case (state_q)
            IDLE, TURN: begin
               if (found_d) begin
                  state_q    <= GRANT;
                  enable_q   <= win_oh_d;
                  grant_id_q <= win_d;
                  last_q     <= win_d;
`ifdef BUS_ARB_TIMEOUT_EN
                  hold_q     <= '0;
`endif
               end else begin
                  state_q  <= IDLE;
                  enable_q <= '0;
               end
            end
            GRANT: begin
               if (!req[grant_id_q]) begin
                  state_q  <= TURN;
                  enable_q <= '0;
               end
`ifdef BUS_ARB_TIMEOUT_EN
               else if (hold_q == HW'(MAX_HOLD - 1)) begin
                  state_q     <= TURN;
                  enable_q    <= '0;
                  preempted_q <= 1'b1;
               end else if (hold_q != {HW{1'b1}}) begin
                  hold_q <= hold_q + HW'(1);
               end
`endif
            end
            default: begin
               state_q  <= IDLE;
               enable_q <= '0;
            end
         endcase
      end
   end

   assign enable   = enable_q;
   assign grant_id = grant_id_q;
   assign bus_busy = |enable_q;
`ifdef BUS_ARB_TIMEOUT_EN
   assign preempted = preempted_q;
`else
   assign preempted = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expected enable/preempt per edge go through a scoreboard queue.
module tb_bus_arbiter;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] enable;
   logic [1:0]   grant_id;
   logic         bus_busy;
   logic         preempted;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [N-1:0] en;
      logic         pre;
   } exp_t;
   exp_t sb[$];

   bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .enable(enable),
      .grant_id(grant_id), .bus_busy(bus_busy), .preempted(preempted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive req, expect e/p to be visible after the next rising edge.
   task automatic cyc(input string tag, input logic [N-1:0] r, input logic [N-1:0] e, input logic p);
      exp_t x;
      logic [1:0] gid;
      req = r;
      sb.push_back('{en: e, pre: p});
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk({tag, ".enable"}, 8'(enable), 8'(x.en));
      chk({tag, ".busy"}, 8'(bus_busy), 8'(|x.en));
      chk({tag, ".preempted"}, 8'(preempted), 8'(x.pre));
      chk({tag, ".onehot"}, 8'($countones(enable) <= 1), 8'd1);
      if (x.en != '0) begin
         gid = '0;
         for (int i = 0; i < N; i++) if (x.en[i]) gid = 2'(i);
         chk({tag, ".grant_id"}, 8'(grant_id), 8'(gid));
         chk({tag, ".req_at_grant"}, 8'(r[grant_id]), 8'd1);
      end
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      req = '0;
      @(posedge clk);
      #1;
      chk({tag, ".rst_enable"}, 8'(enable), 8'h0);
      chk({tag, ".rst_busy"}, 8'(bus_busy), 8'h0);
      chk({tag, ".rst_gid"}, 8'(grant_id), 8'h0);
      chk({tag, ".rst_pre"}, 8'(preempted), 8'h0);
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset and first grant
      do_reset("first");
      cyc("first.g0", 4'b0101, 4'b0001, 1'b0);
      cyc("first.turn", 4'b0100, 4'b0000, 1'b0);
      cyc("first.g2", 4'b0100, 4'b0100, 1'b0);
      cyc("first.drop", 4'b0000, 4'b0000, 1'b0);
      cyc("first.idle", 4'b0000, 4'b0000, 1'b0);

      // Round robin, 2 cycles each, then release for one cycle
      do_reset("rr");
      for (int k = 0; k < 5; k++) begin
         logic [N-1:0] o;
         o = 4'(1 << (k % N));
         cyc("rr.grant", 4'b1111, o, 1'b0);
         if (k < 4) begin
            cyc("rr.hold", 4'b1111, o, 1'b0);
            cyc("rr.turn", 4'b1111 & ~o, 4'b0000, 1'b0);
         end
      end

      // Async reset mid-grant
      do_reset("async");
      cyc("async.g1", 4'b0010, 4'b0010, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("async.enable_now", 8'(enable), 8'h0);
      chk("async.busy_now", 8'(bus_busy), 8'h0);
      #2 rst_n = 1'b1;
      cyc("async.regrant", 4'b0010, 4'b0010, 1'b0);
      cyc("async.turn", 4'b0000, 4'b0000, 1'b0);
      cyc("async.idle", 4'b0000, 4'b0000, 1'b0);

      // Single streamer on source 3: enable 1,1,1,0 repeating
      for (int k = 0; k < 3; k++) begin
         cyc("stream.a", 4'b1000, 4'b1000, 1'b0);
         cyc("stream.b", 4'b1000, 4'b1000, 1'b0);
         cyc("stream.c", 4'b1000, 4'b1000, 1'b0);
         cyc("stream.gap", 4'b0000, 4'b0000, 1'b0);
      end
      cyc("stream.idle", 4'b0000, 4'b0000, 1'b0);

      // Idle for 20 cycles, then a single-cycle pulse on source 2
      do_reset("idle");
      for (int k = 0; k < 20; k++) cyc("idle.quiet", 4'b0000, 4'b0000, 1'b0);
      cyc("idle.pulse", 4'b0100, 4'b0100, 1'b0);
      cyc("idle.turn", 4'b0000, 4'b0000, 1'b0);
      cyc("idle.back", 4'b0000, 4'b0000, 1'b0);

      // Owner drops while another raises in the same cycle
      cyc("handoff.g0", 4'b0001, 4'b0001, 1'b0);
      cyc("handoff.turn", 4'b0010, 4'b0000, 1'b0);
      cyc("handoff.g1", 4'b0010, 4'b0010, 1'b0);
      cyc("handoff.end", 4'b0000, 4'b0000, 1'b0);

      // Timeout behaviour with two continuous requesters
      do_reset("tmo");
`ifdef BUS_ARB_TIMEOUT_EN
      for (int k = 0; k < 8; k++) cyc("tmo.own0", 4'b0011, 4'b0001, 1'b0);
      cyc("tmo.pre0", 4'b0011, 4'b0000, 1'b1);
      for (int k = 0; k < 8; k++) cyc("tmo.own1", 4'b0011, 4'b0010, 1'b0);
      cyc("tmo.pre1", 4'b0011, 4'b0000, 1'b1);
      cyc("tmo.back0", 4'b0011, 4'b0001, 1'b0);
`else
      for (int k = 0; k < 20; k++) cyc("tmo.hold0", 4'b0011, 4'b0001, 1'b0);
`endif
      cyc("tmo.drop", 4'b0000, 4'b0000, 1'b0);
      cyc("tmo.idle", 4'b0000, 4'b0000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
